pc_branch_unit: RTL and testbench



---
 rtl/pc_branch_unit_pkg.sv | 32 +++
 rtl/pc_branch_unit_branch_cond.sv | 32 +++
 rtl/pc_branch_unit.sv | 179 +++++++++++++++++
 tb/tb_pc_branch_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pc_branch_unit_pkg.sv
// pcb_pkg: shared types for the PC/branch control stage.
//   br_op_e  : branch opcode encodings carried on br_op.
//   state_e  : control FSM states (RUN, MEM_WAIT, FLUSH).
//   flush_cnt_width() : width of the post-redirect flush counter.
package pcb_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_J    = 3'b001,
    BR_BRZ  = 3'b010,
    BR_BRN  = 3'b011,
    BR_JM   = 3'b100
  } br_op_e;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  // Counter must hold the value FLUSH_CYCLES itself. $clog2(1) is 0, so a
  // zero-cycle flush still gets a one-bit (unused) counter.
  function automatic int flush_cnt_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage : pcb_pkg

// File: rtl/pc_branch_unit_branch_cond.sv
// branch_cond: combinational branch decision.
//   br_op  in  3  branch opcode (unknown codes behave as NONE)
//   z_flag in  1  latched zero flag
//   n_flag in  1  latched negative flag
//   taken  out 1  direct redirect to target (J, BRZ&z, BRN&n)
//   is_jm  out 1  memory-indirect jump; handled separately from taken
module branch_cond
  import pcb_pkg::*;
(
  input  logic [2:0] br_op,
  input  logic       z_flag,
  input  logic       n_flag,
  output logic       taken,
  output logic       is_jm
);

  always_comb begin
    taken = 1'b0;
    is_jm = 1'b0;
    case (br_op)
      BR_J:    taken = 1'b1;
      BR_BRZ:  taken = z_flag;
      BR_BRN:  taken = n_flag;
      BR_JM:   is_jm = 1'b1;
      default: begin
        taken = 1'b0;
        is_jm = 1'b0;
      end
    endcase
  end

endmodule : branch_cond

// File: rtl/pc_branch_unit.sv
// pc_branch_unit: owns the program counter downstream of the ALU.
// Latches Z/N from flag-writing instructions, resolves J/BRZ/BRN against the
// latched flags, redirects the PC, raises flush for FLUSH_CYCLES non-held
// cycles after a redirect, and performs the JM memory-indirect fetch.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   instr_valid, hold        instruction valid, downstream stall
//   br_op, target            branch opcode and target / JM address
//   flag_we, alu_z, alu_n    flag write enable and ALU flags
//   mem_rdata, mem_rvalid    JM read return
//   mem_req, mem_addr        JM read request (registered, held until rvalid)
//   pc                       current program counter
//   flush                    squash the younger in-flight instruction
//   stall                    upstream hold while a JM read is outstanding
//   z_flag, n_flag           latched flags
module pc_branch_unit
  import pcb_pkg::*;
#(
  parameter int              PC_W         = 32,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic            hold,
  input  logic [2:0]      br_op,
  input  logic [PC_W-1:0] target,
  input  logic            flag_we,
  input  logic            alu_z,
  input  logic            alu_n,
  input  logic [PC_W-1:0] mem_rdata,
  input  logic            mem_rvalid,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  output logic [PC_W-1:0] pc,
  output logic            flush,
  output logic            stall,
  output logic            z_flag,
  output logic            n_flag
);

  localparam int CNT_W = flush_cnt_width(FLUSH_CYCLES);
  localparam bit FLUSH_EN = (FLUSH_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e          state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [PC_W-1:0] mem_addr_reg, mem_addr_next;
  logic            mem_req_reg, mem_req_next;
  logic            flush_reg, flush_next;
  logic            z_reg, z_next;
  logic            n_reg, n_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic            taken;
  logic            is_jm;
  logic [PC_W-1:0] pc_inc;

  // Decision always uses the latched flags so a flag-writing branch sees the
  // flags from the previous flag writer.
  branch_cond u_branch_cond (
    .br_op  (br_op),
    .z_flag (z_reg),
    .n_flag (n_reg),
    .taken  (taken),
    .is_jm  (is_jm)
  );

  // Natural modulo-2^PC_W wrap.
  assign pc_inc = pc_reg + PC_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= RUN;
      pc_reg       <= RESET_PC;
      mem_addr_reg <= '0;
      mem_req_reg  <= 1'b0;
      flush_reg    <= 1'b0;
      z_reg        <= 1'b0;
      n_reg        <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      mem_addr_reg <= mem_addr_next;
      mem_req_reg  <= mem_req_next;
      flush_reg    <= flush_next;
      z_reg        <= z_next;
      n_reg        <= n_next;
      cnt_reg      <= cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    mem_addr_next = mem_addr_reg;
    mem_req_next  = mem_req_reg;
    flush_next    = flush_reg;
    z_next        = z_reg;
    n_next        = n_reg;
    cnt_next      = cnt_reg;

    case (state_reg)
      RUN: begin
        if (!hold) begin
          if (instr_valid) begin
            if (flag_we) begin
              z_next = alu_z;
              n_next = alu_n;
            end
            if (is_jm) begin
              // PC holds while the indirect target is fetched.
              mem_req_next  = 1'b1;
              mem_addr_next = target;
              state_next    = MEM_WAIT;
            end else if (taken) begin
              pc_next = target;
              if (FLUSH_EN) begin
                state_next = FLUSH;
                cnt_next   = CNT_LOAD;
                flush_next = 1'b1;
              end
            end else begin
              pc_next = pc_inc;
            end
          end else begin
            pc_next = pc_inc;
          end
        end
      end

      MEM_WAIT: begin
        // hold is deliberately ignored; request stays stable until rvalid.
        if (mem_rvalid) begin
          mem_req_next = 1'b0;
          pc_next      = mem_rdata;
          if (FLUSH_EN) begin
            state_next = FLUSH;
            cnt_next   = CNT_LOAD;
            flush_next = 1'b1;
          end else begin
            state_next = RUN;
          end
        end
      end

      FLUSH: begin
        // Younger slots are being squashed: instr_valid/br_op/flag_we unused.
        if (!hold) begin
          pc_next  = pc_inc;
          cnt_next = cnt_reg - CNT_ONE;
          if (cnt_reg == CNT_ONE) begin
            flush_next = 1'b0;
            state_next = RUN;
          end
        end
      end

      default: begin
        state_next   = RUN;
        flush_next   = 1'b0;
        mem_req_next = 1'b0;
        cnt_next     = '0;
      end
    endcase
  end

  assign pc       = pc_reg;
  assign mem_req  = mem_req_reg;
  assign mem_addr = mem_addr_reg;
  assign flush    = flush_reg;
  assign z_flag   = z_reg;
  assign n_flag   = n_reg;
  assign stall    = (state_reg == MEM_WAIT);

endmodule : pc_branch_unit

// File: tb/tb_pc_branch_unit.sv
module tb_pc_branch_unit;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst, instr_valid, hold, flag_we, alu_z, alu_n, mem_rvalid;
  logic [2:0]  br_op;
  logic [31:0] target, mem_rdata;
  logic        mem_req, flush, stall, z_flag, n_flag;
  logic [31:0] mem_addr, pc;

  int errors = 0;
  int checks = 0;

  // Reference model: architectural view (program counter, flags, how many
  // squash cycles remain, whether an indirect fetch is outstanding).
  logic [31:0] m_pc, m_addr;
  logic        m_z, m_n, m_waiting;
  int          m_flush_left;

  always #5 clk = ~clk;

  pc_branch_unit #(.PC_W(32), .RESET_PC(32'h0), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .hold(hold),
    .br_op(br_op), .target(target), .flag_we(flag_we), .alu_z(alu_z),
    .alu_n(alu_n), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_req(mem_req), .mem_addr(mem_addr), .pc(pc), .flush(flush),
    .stall(stall), .z_flag(z_flag), .n_flag(n_flag)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advances the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic old_z, old_n, redirect;
    if (rst) begin
      m_pc = 32'h0; m_addr = 32'h0; m_z = 0; m_n = 0;
      m_waiting = 0; m_flush_left = 0;
    end else if (m_waiting) begin
      if (mem_rvalid) begin
        m_waiting = 0;
        m_pc = mem_rdata;
        m_flush_left = FC;
      end
    end else if (m_flush_left > 0) begin
      if (!hold) begin
        m_pc = m_pc + 32'd1;
        m_flush_left--;
      end
    end else if (!hold) begin
      if (!instr_valid) begin
        m_pc = m_pc + 32'd1;
      end else begin
        old_z = m_z; old_n = m_n;
        if (flag_we) begin m_z = alu_z; m_n = alu_n; end
        redirect = (br_op == 3'd1) || (br_op == 3'd2 && old_z) || (br_op == 3'd3 && old_n);
        if (br_op == 3'd4) begin
          m_waiting = 1;
          m_addr = target;
        end else if (redirect) begin
          m_pc = target;
          m_flush_left = FC;
        end else begin
          m_pc = m_pc + 32'd1;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic iv, input logic h, input logic [2:0] op,
                      input logic [31:0] tg, input logic fw, input logic az, input logic an,
                      input logic [31:0] rd, input logic rv);
    @(negedge clk);
    rst = r; instr_valid = iv; hold = h; br_op = op; target = tg;
    flag_we = fw; alu_z = az; alu_n = an; mem_rdata = rd; mem_rvalid = rv;
    model_step();
    @(posedge clk);
    #1;
    $display("t=%0t rst=%0b iv=%0b hold=%0b op=%0d tgt=%h rv=%0b | pc=%h flush=%0b stall=%0b req=%0b addr=%h z=%0b n=%0b",
             $time, r, iv, h, op, tg, rv, pc, flush, stall, mem_req, mem_addr, z_flag, n_flag);
    check("pc", pc, m_pc);
    check("flush", 32'(flush), 32'(m_flush_left > 0));
    check("stall", 32'(stall), 32'(m_waiting));
    check("mem_req", 32'(mem_req), 32'(m_waiting));
    check("mem_addr", mem_addr, m_addr);
    check("z_flag", 32'(z_flag), 32'(m_z));
    check("n_flag", 32'(n_flag), 32'(m_n));
  endtask

  initial begin
    rst = 1; instr_valid = 0; hold = 0; br_op = 0; target = 0;
    flag_we = 0; alu_z = 0; alu_n = 0; mem_rdata = 0; mem_rvalid = 0;

    // Reset then three NONE cycles.
    step(1, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
    check("reset_pc", pc, 32'h0);
    check("reset_flush", 32'(flush), 32'h0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 3'd0, 0, 0, 0, 0, 0, 0);
    check("none_pc3", pc, 32'h3);

    // Z write, then BRZ taken with flush; branches during flush ignored.
    step(0, 1, 0, 3'd0, 0, 1, 1, 0, 0, 0);
    check("z_latched", 32'(z_flag), 32'h1);
    step(0, 1, 0, 3'd2, 32'h40, 0, 0, 0, 0, 0);
    check("brz_pc", pc, 32'h40);
    check("brz_flush", 32'(flush), 32'h1);
    step(0, 1, 0, 3'd1, 32'h99, 1, 0, 1, 0, 0);
    check("flush1_pc", pc, 32'h41);
    step(0, 1, 0, 3'd1, 32'h99, 0, 0, 0, 0, 0);
    check("flush2_pc", pc, 32'h42);
    check("flush_end", 32'(flush), 32'h0);

    // N=0 written, BRN not taken.
    step(0, 1, 0, 3'd0, 0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 3'd3, 32'h80, 0, 0, 0, 0, 0);
    check("brn_nt_pc", pc, 32'h44);

    // JM with rvalid in the entry cycle (must be ignored), 3-cycle wait.
    step(0, 1, 0, 3'd4, 32'h10, 0, 0, 0, 32'hdead, 1);
    check("jm_pc_hold", pc, 32'h44);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 3'd0, 0, 0, 0, 0, 0, 0);
      check("jm_wait_addr", mem_addr, 32'h10);
      check("jm_wait_stall", 32'(stall), 32'h1);
    end
    step(0, 0, 0, 3'd0, 0, 0, 0, 0, 32'h200, 1);
    check("jm_accept_pc", pc, 32'h200);
    check("jm_req_drop", 32'(mem_req), 32'h0);
    step(0, 1, 0, 3'd0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 3'd0, 0, 0, 0, 0, 0, 0);

    // PC wrap: land on FFFFFFFD, flush to FFFFFFFF, NONE wraps to 0.
    step(0, 1, 0, 3'd1, 32'hFFFF_FFFD, 0, 0, 0, 0, 0);
    step(0, 1, 0, 3'd0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 3'd0, 0, 0, 0, 0, 0, 0);
    check("pre_wrap_pc", pc, 32'hFFFF_FFFF);
    step(0, 1, 0, 3'd0, 0, 0, 0, 0, 0, 0);
    check("wrap_pc", pc, 32'h0);

    // Reset while waiting on JM.
    step(0, 1, 0, 3'd4, 32'h20, 0, 0, 0, 0, 0);
    step(0, 1, 0, 3'd0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 3'd0, 0, 0, 0, 0, 32'h55, 1);
    check("rst_wait_pc", pc, 32'h0);
    check("rst_wait_req", 32'(mem_req), 32'h0);
    check("rst_wait_stall", 32'(stall), 32'h0);

    // Hold during FLUSH and during RUN.
    step(0, 1, 0, 3'd1, 32'h300, 0, 0, 0, 0, 0);
    step(0, 1, 1, 3'd0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 3'd0, 0, 0, 0, 0, 0, 0);
    check("hold_flush_pc", pc, 32'h300);
    check("hold_flush_flag", 32'(flush), 32'h1);
    step(0, 1, 0, 3'd0, 0, 0, 0, 0, 0, 0);
    check("hold_flush_still", 32'(flush), 32'h1);
    step(0, 1, 0, 3'd0, 0, 0, 0, 0, 0, 0);
    check("hold_flush_done", 32'(flush), 32'h0);
    check("hold_flush_pc2", pc, 32'h302);
    step(0, 1, 1, 3'd1, 32'h500, 1, 1, 1, 0, 0);
    step(0, 1, 1, 3'd0, 0, 1, 1, 1, 0, 0);
    check("hold_run_pc", pc, 32'h302);
    check("hold_run_z", 32'(z_flag), 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 63) == 0), 1'($urandom), ($urandom_range(0, 3) == 0),
           3'($urandom_range(0, 7)), $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom, ($urandom_range(0, 2) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pc_branch_unit
